// File: rtl/lowp_pkg.sv
// Shared constants for the boxcar low-pass filter chain and a constant-width helper.
package lowp_pkg;

  localparam int unsigned LOWP_WIDTH  = 28;
  localparam int unsigned LOWP_WINDOW = 1024;

  // Number of bits needed to index 'value' distinct entries; 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lowp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module lowp_sync_fifo
  import lowp_pkg::*;
#(
  parameter int unsigned WIDTH = LOWP_WIDTH,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // The slot freed by a same-cycle pop lets a push into a full FIFO proceed.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock_in) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lowp_decim_fifo.sv
// Drops filter output until the window has filled, keeps every DECIM-th enabled sample, and queues it for the reader.
module lowp_decim_fifo
  import lowp_pkg::*;
#(
  parameter int unsigned WIDTH  = LOWP_WIDTH,
  parameter int unsigned DECIM  = 16,
  parameter int unsigned SETTLE = LOWP_WINDOW,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                      clock_in,
  input  logic                      reset,
  input  logic                      enable,
  input  logic signed [WIDTH-1:0]   signal_in,
  output logic                      out_valid,
  output logic signed [WIDTH-1:0]   out_data,
  input  logic                      out_ready,
  output logic [clog2(DEPTH):0]     fifo_count,
  output logic                      settled,
  output logic                      overflow
);

  localparam int unsigned SW = clog2(SETTLE + 1);
  localparam int unsigned DW = clog2(DECIM + 1);

  logic [SW-1:0]    settle_cnt;
  logic [DW-1:0]    decim_cnt;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;
  logic [WIDTH-1:0] head;

  assign push      = settled & enable & (decim_cnt == DW'(DECIM - 1));
  assign pop       = out_valid & out_ready;
  assign out_valid = ~empty;
  assign out_data  = head;

  // Settle counter: settled latches once SETTLE enabled cycles have passed.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      settle_cnt <= '0;
      settled    <= 1'b0;
    end else if (enable & ~settled) begin
      settle_cnt <= settle_cnt + SW'(1);
      if (settle_cnt == SW'(SETTLE - 1)) settled <= 1'b1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      decim_cnt <= '0;
    end else if (settled & enable) begin
      decim_cnt <= (decim_cnt == DW'(DECIM - 1)) ? '0 : decim_cnt + DW'(1);
    end
  end

  // Sticky flag: a kept sample found no room and no same-cycle pop.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push & full & ~pop) begin
      overflow <= 1'b1;
    end
  end

  lowp_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_in (clock_in),
    .reset    (reset),
    .push     (push),
    .din      (signal_in),
    .pop      (pop),
    .dout     (head),
    .empty    (empty),
    .full     (full),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_lowp_decim_fifo.sv
// Directed bench for lowp_decim_fifo with DECIM=4, SETTLE=8, DEPTH=16.
module tb_lowp_decim_fifo;

  localparam int unsigned W = 28;

  logic                clock_in  = 1'b0;
  logic                reset     = 1'b1;
  logic                enable    = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] signal_in = '0;
  logic signed [W-1:0] out_data;
  logic                out_valid;
  logic                settled;
  logic                overflow;
  logic [4:0]          fifo_count;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] got [$];

  always #5 clock_in = ~clock_in;

  lowp_decim_fifo #(
    .WIDTH  (28),
    .DECIM  (4),
    .SETTLE (8),
    .DEPTH  (16)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .enable     (enable),
    .signal_in  (signal_in),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .settled    (settled),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record a handshake just before the edge, then settle past it.
  task automatic cycle();
    @(negedge clock_in);
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    got.delete();
  endtask

  function automatic logic [W-1:0] got_at(input int k);
    if (k < got.size()) return got[k];
    return 'x;
  endfunction

  initial begin
    // 1: reset state, continuous ramp with enable high
    do_reset();
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_count", W'(fifo_count), W'(0));
    chk("rst_settled", W'(settled), W'(0));
    chk("rst_overflow", W'(overflow), W'(0));
    chk("rst_data", out_data, W'(0));
    enable = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 32; j++) begin
      signal_in = W'(j);
      cycle();
      if (j == 6) chk("t1_settled_early", W'(settled), W'(0));
      if (j == 7) chk("t1_settled", W'(settled), W'(1));
      if (j == 10) chk("t1_valid_before", W'(out_valid), W'(0));
      if (j == 11) begin
        chk("t1_valid_first", W'(out_valid), W'(1));
        chk("t1_data_first", out_data, W'(11));
      end
    end
    chk("t1_n", W'(got.size()), W'(5));
    for (int k = 0; k < 5; k++) chk("t1_data", got_at(k), W'(11 + 4 * k));

    // 2: enable toggling every clock
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < 42; j++) begin
      enable = ((j % 2) == 1);
      signal_in = W'(j);
      cycle();
      if (j == 14) chk("t2_settled_early", W'(settled), W'(0));
      if (j == 15) chk("t2_settled", W'(settled), W'(1));
    end
    chk("t2_n", W'(got.size()), W'(3));
    for (int k = 0; k < 3; k++) chk("t2_data", got_at(k), W'(23 + 8 * k));

    // 3: stalled consumer fills the FIFO, the 17th kept sample overflows
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int j = 0; j < 76; j++) begin
      signal_in = W'(100 + j);
      cycle();
      if (j == 71) begin
        chk("t3_full_count", W'(fifo_count), W'(16));
        chk("t3_full_ovf", W'(overflow), W'(0));
        chk("t3_stall_valid", W'(out_valid), W'(1));
        chk("t3_stall_head", out_data, W'(111));
      end
      if (j == 74) chk("t3_ovf_before", W'(overflow), W'(0));
      if (j == 75) begin
        chk("t3_ovf_set", W'(overflow), W'(1));
        chk("t3_ovf_count", W'(fifo_count), W'(16));
      end
    end
    enable = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 17; j++) cycle();
    chk("t3_n", W'(got.size()), W'(16));
    for (int k = 0; k < 16; k++) chk("t3_data", got_at(k), W'(111 + 4 * k));
    chk("t3_drained", W'(fifo_count), W'(0));
    chk("t3_empty", W'(out_valid), W'(0));
    chk("t3_ovf_sticky", W'(overflow), W'(1));

    // 4: push and pop in the same cycle while full
    do_reset();
    enable = 1'b1;
    for (int j = 0; j < 76; j++) begin
      signal_in = W'(200 + j);
      out_ready = (j == 75);
      cycle();
      if (j == 71) chk("t4_full", W'(fifo_count), W'(16));
      if (j == 75) begin
        chk("t4_count_same", W'(fifo_count), W'(16));
        chk("t4_no_ovf", W'(overflow), W'(0));
      end
    end
    enable = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 18; j++) cycle();
    chk("t4_n", W'(got.size()), W'(17));
    for (int k = 0; k < 17; k++) chk("t4_data", got_at(k), W'(211 + 4 * k));
    chk("t4_ovf_end", W'(overflow), W'(0));

    // 5: sign and bit-exact pass-through
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 17; j++) begin
      signal_in = (j == 15) ? 28'h8000000 : 28'hFFFFFFF;
      cycle();
    end
    chk("t5_n", W'(got.size()), W'(2));
    chk("t5_all_ones", got_at(0), 28'hFFFFFFF);
    chk("t5_min", got_at(1), 28'h8000000);
    chk("t5_neg", W'($signed(got_at(1)) < 0), W'(1));

    // 6: reset with five samples queued
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int j = 0; j < 28; j++) begin
      signal_in = W'(j);
      cycle();
    end
    chk("t6_queued", W'(fifo_count), W'(5));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_valid", W'(out_valid), W'(0));
    chk("t6_count", W'(fifo_count), W'(0));
    chk("t6_settled", W'(settled), W'(0));
    chk("t6_ovf", W'(overflow), W'(0));
    chk("t6_data", out_data, W'(0));
    for (int j = 0; j < 8; j++) begin
      cycle();
      if (j == 6) chk("t6_resettle_early", W'(settled), W'(0));
      if (j == 7) chk("t6_resettle", W'(settled), W'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
